eth_tx_arbiter: RTL

//  Shares the single UDP/Ethernet TX engine between up to 4 capture channels
//  (ADC / logic-analyser FIFOs). Splits each channel's transfer into packets of
//  at most MAX_PAYLOAD bytes, arbitrates round-robin per packet and waits for

---
 rtl/eth_tx_arbiter_if.sv | 32 +++
 rtl/eth_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : eth_tx_arbiter_if
// Brief   : Channel request/FIFO-level bundle and TX-engine packet handshake
//           shared between eth_tx_arbiter (master) and its environment (slave).
// Revision: 1.0  initial release
// ============================================================================
interface eth_tx_arbiter_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]    ch_req;
  logic [32*NUM_CH-1:0] ch_total_num;
  logic [11*NUM_CH-1:0] ch_fifo_cnt;
  logic                 eth_tx_done;
  logic                 pkt_tx_en;
  logic [15:0]          pkt_length;
  logic [1:0]           pkt_ch_sel;
  logic [NUM_CH-1:0]    ch_busy;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_abort;

  modport master (
    input  ch_req, ch_total_num, ch_fifo_cnt, eth_tx_done,
    output pkt_tx_en, pkt_length, pkt_ch_sel, ch_busy, ch_done, ch_abort
  );

  modport slave (
    output ch_req, ch_total_num, ch_fifo_cnt, eth_tx_done,
    input  pkt_tx_en, pkt_length, pkt_ch_sel, ch_busy, ch_done, ch_abort
  );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : eth_tx_arbiter
// Brief   : Round-robin, per-packet sharing of the UDP/Ethernet TX engine
//           between capture channels. Optional FIFO-fill watchdog enabled by
//           defining ETH_ARB_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
module eth_tx_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int MAX_PAYLOAD = 1472,
  parameter int GAP_CYCLES  = 128,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  wire logic        clk125M,
  input  wire logic        reset,
  eth_tx_arbiter_if.master bus
);

  localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [31:0]         r_rem [NUM_CH];
  logic [NUM_CH-1:0]   w_busy;
  logic [NUM_CH-1:0]   w_sel_hit;

  logic [1:0]          r_last_grant;
  logic [1:0]          r_sel;
  logic [15:0]         r_pkt_length;
  logic                r_pkt_tx_en;
  logic [NUM_CH-1:0]   r_ch_done;
  logic [c_GAP_W-1:0]  r_gap_cnt;

  logic                w_found;
  logic [1:0]          w_grant;
  logic [31:0]         w_rem_grant;
  logic [31:0]         w_rem_sel;
  logic [10:0]         w_fifo_sel;
  logic [32:0]         w_bytes;
  logic [15:0]         w_len;
  logic [31:0]         w_half;
  logic [31:0]         w_rem_next;
  logic                w_fifo_ok;

  logic                w_tx_pulse;
  logic                w_load_pkt;
  logic                w_take_done;
  logic                w_abort;

  // ---------------------------------------------------------------------------
  // Per-channel remaining-sample counters
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_busy[i]    = (r_rem[i] != 32'd0);
    assign w_sel_hit[i] = (r_sel == 2'(i));

    always_ff @(posedge clk125M or posedge reset) begin
      if (reset) begin
        r_rem[i] <= 32'd0;
      end else if (bus.ch_req[i] && !w_busy[i] && (bus.ch_total_num[i*32 +: 32] != 32'd0)) begin
        r_rem[i] <= bus.ch_total_num[i*32 +: 32];
      end else if (w_take_done && w_sel_hit[i]) begin
        r_rem[i] <= w_rem_next;
      end else if (w_abort && w_sel_hit[i]) begin
        r_rem[i] <= 32'd0;
      end
    end
  end

  // Round-robin search starting just after the previous grant
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last_grant;
    for (int off = 1; off <= NUM_CH; off++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && w_busy[i] && (((int'(r_last_grant) + off) % NUM_CH) == i)) begin
          w_found = 1'b1;
          w_grant = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_rem_grant = 32'd0;
    w_rem_sel   = 32'd0;
    w_fifo_sel  = 11'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == 2'(i)) begin
        w_rem_grant = r_rem[i];
      end
      if (r_sel == 2'(i)) begin
        w_rem_sel  = r_rem[i];
        w_fifo_sel = bus.ch_fifo_cnt[i*11 +: 11];
      end
    end
  end

  // Byte count is formed at 33 bits so rem >= 2^31 still clips correctly
  assign w_bytes    = {w_rem_grant, 1'b0};
  assign w_len      = (w_bytes > 33'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : w_bytes[15:0];
  assign w_half     = {17'd0, r_pkt_length[15:1]};
  assign w_rem_next = w_rem_sel - w_half;
  assign w_fifo_ok  = ({5'd0, w_fifo_sel} >= {1'b0, r_pkt_length[15:1]});

`ifdef ETH_ARB_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic [NUM_CH-1:0] r_ch_abort;

  always_ff @(posedge clk125M or posedge reset) begin
    if (reset) begin
      r_wd_cnt   <= '0;
      r_ch_abort <= '0;
    end else begin
      r_ch_abort <= w_abort ? w_sel_hit : '0;
      if (r_state == S_WAIT_DATA) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign bus.ch_abort = r_ch_abort;
`else
  // TIMEOUT_CYC only shapes the watchdog build; nothing to elaborate here
  if (TIMEOUT_CYC < 1) begin : g_no_watchdog
  end

  assign bus.ch_abort = '0;
`endif

  // ---------------------------------------------------------------------------
  // Packet sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk125M or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_pulse   = 1'b0;
    w_load_pkt   = 1'b0;
    w_take_done  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_busy) begin
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_found) begin
          w_load_pkt   = 1'b1;
          w_state_next = S_WAIT_DATA;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (w_fifo_ok) begin
          w_tx_pulse   = 1'b1;
          w_state_next = S_WAIT_DONE;
        end
`ifdef ETH_ARB_TIMEOUT_EN
        else if (r_wd_cnt == c_WD_W'(TIMEOUT_CYC - 1)) begin
          w_abort      = 1'b1;
          w_state_next = S_GAP;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (bus.eth_tx_done) begin
          w_take_done  = 1'b1;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet descriptor, pulses and gap counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk125M or posedge reset) begin
    if (reset) begin
      r_last_grant <= 2'(NUM_CH - 1);
      r_sel        <= 2'd0;
      r_pkt_length <= 16'd0;
      r_pkt_tx_en  <= 1'b0;
      r_ch_done    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_pkt_tx_en <= w_tx_pulse;
      r_ch_done   <= (w_take_done && (w_rem_next == 32'd0)) ? w_sel_hit : '0;
      if (w_load_pkt) begin
        r_pkt_length <= w_len;
        r_sel        <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign bus.pkt_tx_en  = r_pkt_tx_en;
  assign bus.pkt_length = r_pkt_length;
  assign bus.pkt_ch_sel = r_sel;
  assign bus.ch_busy    = w_busy;
  assign bus.ch_done    = r_ch_done;

endmodule
`default_nettype wire
